// File: rtl/periph_rr_arbiter.sv
// periph_rr_arbiter: the upstream side grants one peripheral RX FIFO at a time in
// round-robin order. Each grant lasts for at most MAX_BURST words and ends early
// when the granted FIFO runs dry. The downstream side steers host words to a
// peripheral TX FIFO using the top three address bits. Out-of-range addresses are
// accepted and counted as drops.
module periph_rr_arbiter #(
    parameter int NUM_PERIPHS  = 8,
    parameter int PACKET_WIDTH = 32,
    parameter int MAX_BURST    = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_PERIPHS-1:0]                   periph_rx_empty,
    input  logic [NUM_PERIPHS-1:0][PACKET_WIDTH-1:0] periph_rx_dout,
    output logic [NUM_PERIPHS-1:0]                   periph_rx_rden,
    output logic [PACKET_WIDTH-1:0]                  up_data,
    output logic                                     up_valid,
    input  logic                                     up_ready,
    input  logic [PACKET_WIDTH-1:0]                  down_data,
    input  logic                                     down_valid,
    output logic                                     down_ready,
    output logic [PACKET_WIDTH-1:0]                  periph_tx_din,
    output logic [NUM_PERIPHS-1:0]                   periph_tx_wren,
    input  logic [NUM_PERIPHS-1:0]                   periph_tx_full,
    output logic [2:0]                               grant_idx,
    output logic                                     busy,
    output logic [15:0]                              drop_count
);

    localparam int               CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic              found_hi, found_lo, found_any;
    logic [2:0]        idx_hi, idx_lo, pick_idx;
    logic              sel_empty;
    logic [PACKET_WIDTH-1:0] sel_dout;
    logic [2:0]        next_ptr;
    logic              accept;
    logic [2:0]        down_addr;
    logic              addr_ok;

    assign down_addr     = down_data[PACKET_WIDTH-1 -: 3];
    assign addr_ok       = int'(down_addr) < NUM_PERIPHS;
    assign periph_tx_din = down_data;
    assign grant_idx     = grant_idx_q;
    assign busy          = (state_q == BURST);
    assign drop_count    = drop_count_q;
    assign next_ptr      = (int'(grant_idx_q) == NUM_PERIPHS - 1) ? 3'd0 : grant_idx_q + 3'd1;

    // Round-robin pick: the lowest non-empty index at or above rr_ptr wins. Otherwise the lowest one below it wins.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = 3'd0;
        idx_lo   = 3'd0;
        for (int i = NUM_PERIPHS - 1; i >= 0; i--) begin
            if (!periph_rx_empty[i]) begin
                if (i >= int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = 3'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = 3'(i);
                end
            end
        end
        found_any = found_hi | found_lo;
        pick_idx  = found_hi ? idx_hi : idx_lo;
    end

    // Select the FIFO head and the empty flag of the granted peripheral.
    always_comb begin
        sel_empty = 1'b1;
        sel_dout  = '0;
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            if (3'(i) == grant_idx_q) begin
                sel_empty = periph_rx_empty[i];
                sel_dout  = periph_rx_dout[i];
            end
        end
    end

    // Upstream FSM next state and outputs. Handshaking is gated off during reset so that an abandoned burst leaves its word in the FIFO.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_idx_d    = grant_idx_q;
        burst_cnt_d    = burst_cnt_q;
        up_valid       = 1'b0;
        up_data        = sel_dout;
        periph_rx_rden = '0;
        accept         = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_any) begin
                    grant_idx_d = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                up_valid = ~sel_empty & ~rst;
                accept   = up_valid & up_ready;
                for (int i = 0; i < NUM_PERIPHS; i++) begin
                    if (3'(i) == grant_idx_q) begin
                        periph_rx_rden[i] = accept;
                    end
                end
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == LAST_CNT) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!up_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Downstream steering. In-range addresses respect the target's full flag. Out-of-range words are always taken and counted as drops, with saturation.
    always_comb begin
        down_ready     = 1'b1;
        periph_tx_wren = '0;
        drop_count_d   = drop_count_q;
        if (addr_ok) begin
            for (int i = 0; i < NUM_PERIPHS; i++) begin
                if (3'(i) == down_addr) begin
                    down_ready        = ~periph_tx_full[i];
                    periph_tx_wren[i] = down_valid & ~periph_tx_full[i];
                end
            end
        end else if (down_valid && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 3'd0;
            grant_idx_q  <= 3'd0;
            burst_cnt_q  <= '0;
            drop_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            burst_cnt_q  <= burst_cnt_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// tb_periph_rr_arbiter: this bench drives the arbiter from FIFO models kept in the bench.
// Each cycle it checks the outputs against a behavioural reference model.
// It uses a second instance with four peripherals to reach the out-of-range address path.
module tb_periph_rr_arbiter;

    localparam int N  = 8;
    localparam int N4 = 4;
    localparam int W  = 32;
    localparam int MB = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         periph_rx_empty;
    logic [N-1:0][W-1:0]  periph_rx_dout;
    logic [N-1:0]         periph_rx_rden;
    logic [W-1:0]         up_data;
    logic                 up_valid;
    logic                 up_ready;
    logic [W-1:0]         down_data;
    logic                 down_valid;
    logic                 down_ready;
    logic [W-1:0]         periph_tx_din;
    logic [N-1:0]         periph_tx_wren;
    logic [N-1:0]         periph_tx_full;
    logic [2:0]           grant_idx;
    logic                 busy;
    logic [15:0]          drop_count;

    logic [N4-1:0]        rx_empty4;
    logic [N4-1:0][W-1:0] rx_dout4;
    logic [N4-1:0]        rx_rden4;
    logic [W-1:0]         up_data4;
    logic                 up_valid4;
    logic                 down_ready4;
    logic [W-1:0]         tx_din4;
    logic [N4-1:0]        tx_wren4;
    logic [N4-1:0]        tx_full4;
    logic [2:0]           grant4;
    logic                 busy4;
    logic [15:0]          drop4;

    assign rx_empty4 = '1;
    assign rx_dout4  = '0;
    assign tx_full4  = periph_tx_full[N4-1:0];

    periph_rr_arbiter #(.NUM_PERIPHS(N), .PACKET_WIDTH(W), .MAX_BURST(MB)) u_dut (
        .clk(clk), .rst(rst),
        .periph_rx_empty(periph_rx_empty), .periph_rx_dout(periph_rx_dout), .periph_rx_rden(periph_rx_rden),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
        .periph_tx_din(periph_tx_din), .periph_tx_wren(periph_tx_wren), .periph_tx_full(periph_tx_full),
        .grant_idx(grant_idx), .busy(busy), .drop_count(drop_count)
    );

    periph_rr_arbiter #(.NUM_PERIPHS(N4), .PACKET_WIDTH(W), .MAX_BURST(MB)) u_dut4 (
        .clk(clk), .rst(rst),
        .periph_rx_empty(rx_empty4), .periph_rx_dout(rx_dout4), .periph_rx_rden(rx_rden4),
        .up_data(up_data4), .up_valid(up_valid4), .up_ready(up_ready),
        .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready4),
        .periph_tx_din(tx_din4), .periph_tx_wren(tx_wren4), .periph_tx_full(tx_full4),
        .grant_idx(grant4), .busy(busy4), .drop_count(drop4)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Peripheral RX FIFOs modelled as circular buffers
    logic [W-1:0] fifo_mem [N][256];
    int           head [N];
    int           tail [N];

    // Reference model: burst ownership, words taken so far, round-robin start point, drop counters
    bit   m_busy;
    int   m_owner, m_taken, m_ptr, m_grant, m_drop8, m_drop4;
    bit   e_valid, e_accept, e_drop8, e_drop4;
    logic [N-1:0] obs_rden;
    bit   prev_busy;

    int   log_grant[$];
    int   log_len[$];

    int   n_compared = 0;
    int   n_mismatch = 0;

    typedef struct {
        logic [2:0] addr;
        bit         valid;
        logic [7:0] full;
        bit         rdy8;
        logic [7:0] wren8;
        bit         rdy4;
        logic [3:0] wren4;
        int         drop4;
    } vec_t;

    vec_t vecs[8];
    int   exp036_g[6] = '{0, 1, 0, 1, 0, 1};
    int   exp036_l[6] = '{16, 16, 16, 16, 8, 8};

    function automatic int fifoSize(input int p);
        return tail[p] - head[p];
    endfunction

    function automatic bit anyPending();
        bit any;
        any = 1'b0;
        for (int p = 0; p < N; p++) if (fifoSize(p) > 0) any = 1'b1;
        return any;
    endfunction

    task automatic pushWord(input int p, input logic [W-1:0] w);
        fifo_mem[p][tail[p] % 256] = w;
        tail[p] = tail[p] + 1;
    endtask

    task automatic refreshRx();
        for (int p = 0; p < N; p++) begin
            periph_rx_empty[p] = (fifoSize(p) == 0);
            periph_rx_dout[p]  = (fifoSize(p) > 0) ? fifo_mem[p][head[p] % 256] : '0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Expected downstream response for an arbiter with n peripherals
    task automatic expectDown(input int n, output bit rdy, output logic [7:0] wren, output bit drp);
        int a;
        a    = int'(down_data[W-1 -: 3]);
        wren = '0;
        if (a < n) begin
            rdy = !periph_tx_full[a];
            if (down_valid && rdy) wren[a] = 1'b1;
            drp = 1'b0;
        end else begin
            rdy = 1'b1;
            drp = down_valid;
        end
    endtask

    // Drive one cycle of inputs and compare every output at the falling edge
    task automatic applyStimulus(input bit r, input bit rdy, input bit dv, input logic [W-1:0] dd, input logic [N-1:0] df);
        logic [W-1:0] exp_data;
        logic [N-1:0] exp_rden;
        bit           r8, r4;
        logic [7:0]   w8, w4;
        rst            = r;
        up_ready       = rdy;
        down_valid     = dv;
        down_data      = dd;
        periph_tx_full = df;
        refreshRx();
        @(negedge clk);
        e_valid  = 1'b0;
        exp_data = '0;
        exp_rden = '0;
        if (m_busy && !r) begin
            e_valid = fifoSize(m_owner) > 0;
            if (e_valid) exp_data = fifo_mem[m_owner][head[m_owner] % 256];
            if (e_valid && rdy) exp_rden[m_owner] = 1'b1;
        end
        e_accept = e_valid && rdy;
        checkOutput("busy", busy, m_busy);
        checkOutput("grant_idx", grant_idx, m_grant);
        checkOutput("up_valid", up_valid, e_valid);
        if (e_valid) checkOutput("up_data", up_data, exp_data);
        checkOutput("rx_rden", periph_rx_rden, exp_rden);
        expectDown(N, r8, w8, e_drop8);
        expectDown(N4, r4, w4, e_drop4);
        checkOutput("down_ready", down_ready, r8);
        checkOutput("tx_wren", periph_tx_wren, w8);
        checkOutput("tx_din", periph_tx_din, dd);
        checkOutput("drop_count", drop_count, m_drop8);
        checkOutput("down_ready4", down_ready4, r4);
        checkOutput("tx_wren4", tx_wren4, w4[3:0]);
        checkOutput("tx_din4", tx_din4, dd);
        checkOutput("drop_count4", drop4, m_drop4);
        checkOutput("busy4", busy4, 0);
        checkOutput("up_valid4", up_valid4, 0);
        checkOutput("rx_rden4", rx_rden4, 0);
        checkOutput("grant4", grant4, 0);
        obs_rden = periph_rx_rden;
        if (busy && !prev_busy) begin
            log_grant.push_back(int'(grant_idx));
            log_len.push_back(0);
        end
        if (periph_rx_rden != '0 && log_len.size() > 0)
            log_len[log_len.size()-1] = log_len[log_len.size()-1] + 1;
        prev_busy = busy;
    endtask

    // Clock edge: advance the reference model, then pop the FIFOs the DUT strobed
    task automatic advanceClock();
        bit found;
        int c;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_owner = 0; m_taken = 0; m_ptr = 0; m_grant = 0; m_drop8 = 0; m_drop4 = 0;
        end else begin
            if (!m_busy) begin
                found = 1'b0;
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr + j) % N;
                    if (!found && fifoSize(c) > 0) begin
                        found = 1'b1; m_grant = c; m_owner = c; m_taken = 0;
                    end
                end
                if (found) m_busy = 1'b1;
            end else if (!e_valid) begin
                m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
            end else if (e_accept) begin
                m_taken++;
                if (m_taken == MB) begin
                    m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
                end
            end
            if (e_drop8 && m_drop8 < 65535) m_drop8++;
            if (e_drop4 && m_drop4 < 65535) m_drop4++;
        end
        for (int p = 0; p < N; p++) if (obs_rden[p] && fifoSize(p) > 0) head[p] = head[p] + 1;
        #1;
        refreshRx();
    endtask

    task automatic runCycle(input bit r, input bit rdy, input bit dv, input logic [W-1:0] dd, input logic [N-1:0] df);
        applyStimulus(r, rdy, dv, dd, df);
        advanceClock();
    endtask

    task automatic resetDut();
        for (int p = 0; p < N; p++) begin head[p] = 0; tail[p] = 0; end
        runCycle(1'b1, 1'b0, 1'b0, '0, '0);
        log_grant.delete();
        log_len.delete();
    endtask

    task automatic runUntilDrained(input int budget, input string tag);
        int cyc;
        cyc = 0;
        while ((anyPending() || m_busy) && cyc < budget) begin
            runCycle(1'b0, 1'b1, 1'b0, '0, '0);
            cyc++;
        end
        checkOutput({tag, "_drained"}, (anyPending() || m_busy), 0);
    endtask

    task automatic checkBurst(input string tag, input int idx, input int g, input int l);
        checkOutput({tag, "_grant"}, (idx < log_grant.size()) ? log_grant[idx] : -1, g);
        checkOutput({tag, "_len"}, (idx < log_len.size()) ? log_len[idx] : -1, l);
    endtask

    // Safety net for a hung handshake
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          r;
        int          seq;
        int          p;
        logic [2:0]  pa;
        bit          rr;
        bit          rd;

        vecs[0] = '{3'd3, 1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 4'h0, 0};
        vecs[1] = '{3'd3, 1'b1, 8'h00, 1'b1, 8'h08, 1'b1, 4'h8, 0};
        vecs[2] = '{3'd6, 1'b1, 8'h00, 1'b1, 8'h40, 1'b1, 4'h0, 0};
        vecs[3] = '{3'd6, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 4'h0, 1};
        vecs[4] = '{3'd6, 1'b1, 8'h00, 1'b1, 8'h40, 1'b1, 4'h0, 2};
        vecs[5] = '{3'd0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 4'h0, 3};
        vecs[6] = '{3'd7, 1'b0, 8'h80, 1'b0, 8'h00, 1'b1, 4'h0, 3};
        vecs[7] = '{3'd5, 1'b1, 8'h00, 1'b1, 8'h20, 1'b1, 4'h0, 3};

        // Power-on reset before the model takes over
        for (int q = 0; q < N; q++) begin head[q] = 0; tail[q] = 0; end
        rst = 1'b1; up_ready = 1'b0; down_valid = 1'b0; down_data = '0; periph_tx_full = '0;
        refreshRx();
        repeat (2) @(posedge clk);
        #1;
        m_busy = 0; m_owner = 0; m_taken = 0; m_ptr = 0; m_grant = 0; m_drop8 = 0; m_drop4 = 0;
        prev_busy = 1'b0; obs_rden = '0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_up_valid", up_valid, 0);
        checkOutput("reset_rden", periph_rx_rden, 0);
        checkOutput("reset_grant", grant_idx, 0);
        checkOutput("reset_drop", drop_count, 0);

        // Single peripheral with five words, and a round-robin pointer that lands after it
        resetDut();
        for (int k = 0; k < 5; k++) pushWord(2, 32'h2200_0000 + k);
        runUntilDrained(40, "t035");
        checkOutput("t035_bursts", log_grant.size(), 1);
        checkBurst("t035", 0, 2, 5);
        checkOutput("t035_fifo2", fifoSize(2), 0);
        log_grant.delete(); log_len.delete();
        pushWord(1, 32'h1100_0000);
        pushWord(4, 32'h4400_0000);
        runUntilDrained(40, "t035b");
        checkBurst("t035b", 0, 4, 1);
        checkBurst("t035b", 1, 1, 1);

        // Two deep FIFOs alternate with full-length and then short bursts
        resetDut();
        for (int k = 0; k < 40; k++) begin
            pushWord(0, 32'h0000_1000 + k);
            pushWord(1, 32'h0100_1000 + k);
        end
        runUntilDrained(300, "t036");
        checkOutput("t036_bursts", log_grant.size(), 6);
        for (int b = 0; b < 6; b++) checkBurst("t036", b, exp036_g[b], exp036_l[b]);

        // Backpressure pattern 1,0,0,1 holds data and pops only on ready
        resetDut();
        for (int k = 0; k < 4; k++) pushWord(3, 32'h3300_0000 + k);
        runCycle(1'b0, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 4; c++) begin
            rd = (c == 0 || c == 3);
            applyStimulus(1'b0, rd, 1'b0, '0, '0);
            checkOutput("t037_data", up_data, (c == 0) ? 32'h3300_0000 : 32'h3300_0001);
            checkOutput("t037_rden3", periph_rx_rden[3], rd);
            advanceClock();
        end
        checkOutput("t037_left", fifoSize(3), 2);
        checkBurst("t037", 0, 3, 2);
        runUntilDrained(40, "t037");

        // Downstream vector table, including full backpressure and out-of-range drops on the four-peripheral instance
        resetDut();
        for (int v = 0; v < 8; v++) begin
            applyStimulus(1'b0, 1'b0, vecs[v].valid, {vecs[v].addr, 29'(32'h0ABC_0000 + v)}, vecs[v].full);
            checkOutput("vec_ready8", down_ready, vecs[v].rdy8);
            checkOutput("vec_wren8", periph_tx_wren, vecs[v].wren8);
            checkOutput("vec_ready4", down_ready4, vecs[v].rdy4);
            checkOutput("vec_wren4", tx_wren4, vecs[v].wren4);
            checkOutput("vec_drop4", drop4, vecs[v].drop4);
            advanceClock();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("vec_drop4_final", drop4, 4);
        checkOutput("vec_drop8_final", drop_count, 0);
        advanceClock();

        // Reset in the middle of a burst from peripheral 1
        resetDut();
        pushWord(0, 32'h0000_0A00);
        for (int k = 0; k < 10; k++) pushWord(1, 32'h0100_0A00 + k);
        r = 0;
        while (fifoSize(1) > 7 && r < 30) begin
            runCycle(1'b0, 1'b1, 1'b1, {3'd6, 29'd0}, '0);
            r++;
        end
        checkOutput("t040_reached", fifoSize(1), 7);
        pushWord(2, 32'h0200_0A00);
        pushWord(0, 32'h0000_0A01);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
        checkOutput("t040_rst_rden", periph_rx_rden, 0);
        advanceClock();
        checkOutput("t040_busy", busy, 0);
        checkOutput("t040_rden", periph_rx_rden, 0);
        checkOutput("t040_drop4", drop4, 0);
        checkOutput("t040_kept", fifoSize(1), 7);
        log_grant.delete(); log_len.delete();
        runUntilDrained(100, "t040");
        checkBurst("t040", 0, 0, 1);

        // Random traffic with occasional resets
        resetDut();
        seq = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 3 == 0) begin
                p = int'($urandom % N);
                if (fifoSize(p) < 20) begin
                    pushWord(p, {p[7:0], 24'(seq)});
                    seq++;
                end
            end
            rr = ($urandom % 400 == 0);
            rd = ($urandom % 4 != 0);
            pa = 3'($urandom);
            applyStimulus(rr, rd, 1'($urandom), {pa, 29'($urandom)}, N'($urandom));
            advanceClock();
        end
        runUntilDrained(800, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/periph_rr_arbiter.md
PERIPH_RR_ARBITER -- requirements
Module: periph_rr_arbiter

Interface
REQ-001 Parameter NUM_PERIPHS, 8, number of attached peripherals; 2..8 supported.
REQ-002 Parameter PACKET_WIDTH, 32, width of one USB packet word.
REQ-003 Parameter MAX_BURST, 16, maximum words taken from one peripheral per grant; 1..256.
REQ-004 clk  input  1  single clock, supplied by the FT601; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 periph_rx_empty  input  NUM_PERIPHS  per-peripheral upstream FIFO empty flag.
REQ-007 periph_rx_dout  input  NUM_PERIPHS x PACKET_WIDTH  per-peripheral FWFT FIFO head word; valid while empty=0.
REQ-008 periph_rx_rden  output  NUM_PERIPHS  per-peripheral pop strobe.
REQ-009 up_data  output  PACKET_WIDTH  word toward FT601 TX path.
REQ-010 up_valid  output  1  up_data valid.
REQ-011 up_ready  input  1  FT601 TX path accepts word this cycle.
REQ-012 down_data  input  PACKET_WIDTH  host-to-peripheral word; address in bits [PACKET_WIDTH-1 -: 3].
REQ-013 down_valid  input  1  down_data valid.
REQ-014 down_ready  output  1  word accepted this cycle.
REQ-015 periph_tx_din  output  PACKET_WIDTH  broadcast write data to all peripheral TX FIFOs.
REQ-016 periph_tx_wren  output  NUM_PERIPHS  one-hot per-peripheral write strobe.
REQ-017 periph_tx_full  input  NUM_PERIPHS  per-peripheral TX FIFO full.
REQ-018 grant_idx  output  3  index of peripheral currently granted.
REQ-019 busy  output  1  1 while in BURST state.
REQ-020 drop_count  output  16  count of downstream words with out-of-range address.

Function
REQ-021 Upstream FSM SHALL have two states: IDLE, BURST.
REQ-022 IDLE: if any periph_rx_empty bit is 0, SHALL select first non-empty index searching upward from rr_ptr with wrap, register it in grant_idx, clear burst_cnt, go to BURST next cycle; else remain IDLE.
REQ-023 BURST: up_valid SHALL equal ~periph_rx_empty[grant_idx]; up_data SHALL equal periph_rx_dout[grant_idx] (combinational mux).
REQ-024 periph_rx_rden[grant_idx] SHALL be up_valid & up_ready in BURST; all other rden bits and all bits in IDLE SHALL be 0.
REQ-025 Each accepted word (up_valid & up_ready) SHALL increment burst_cnt by 1.
REQ-026 BURST SHALL exit to IDLE when a word is accepted with burst_cnt == MAX_BURST-1, or when up_valid == 0 (granted FIFO empty); on exit rr_ptr SHALL become (grant_idx+1) mod NUM_PERIPHS.
REQ-027 up_valid deasserted with up_ready low SHALL NOT be a stall; up_valid high with up_ready low SHALL hold grant, burst_cnt and data unchanged.
REQ-028 IDLE SHALL drive up_valid=0; minimum one IDLE cycle between consecutive bursts (including re-grant to the same peripheral).
REQ-029 Downstream path SHALL be combinational: addr = down_data top 3 bits; if addr < NUM_PERIPHS, down_ready = ~periph_tx_full[addr] and periph_tx_wren[addr] = down_valid & down_ready.
REQ-030 If addr >= NUM_PERIPHS, down_ready SHALL be 1, no wren SHALL assert, and drop_count SHALL increment on down_valid, saturating at 16'hFFFF.
REQ-031 periph_tx_din SHALL equal down_data unconditionally.
REQ-032 Upstream and downstream paths SHALL operate independently in the same cycle.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, rr_ptr=0, grant_idx=0, burst_cnt=0, drop_count=0; busy=0, up_valid=0, periph_rx_rden=0 in the following cycle.
REQ-034 Reset asserted mid-burst SHALL abandon the burst without popping; the unpopped word remains in its FIFO.

Verification
REQ-035 Only periph 2 non-empty with 5 words, up_ready=1 -> grant_idx=2, 5 words out in order, FIFO empties, IDLE, rr_ptr=3.
REQ-036 Periphs 0 and 1 each hold 40 words, MAX_BURST=16 -> grant sequence 0,1,0,1,0,1 with bursts 16,16,16,16,8,8.
REQ-037 Granted, up_ready toggled 1,0,0,1 -> up_data stable while low, rden only in ready cycles, no word lost or duplicated.
REQ-038 down_data address 3 with periph_tx_full[3]=1 then 0 -> down_ready 0 then 1; wren[3] only in second cycle.
REQ-039 NUM_PERIPHS=4, down_valid with address 6 for 3 cycles -> down_ready=1, no wren, drop_count=3.
REQ-040 rst pulsed during burst from periph 1 with up_ready=1 -> next cycle rden=0, busy=0, drop_count=0; arbitration restarts from index 0.
